// File: rtl/display_timing_multi_pkg.sv
// display_timing_pkg
// Shared types and the video mode table for the runtime-selectable display
// timing generator. derive() turns a table entry into the signed counter
// constants used by both the timing core and the mode ROM.
// Ports: none (package).
package display_timing_pkg;

  typedef enum logic [1:0] {
    MODE_640x480  = 2'd0,
    MODE_800x600  = 2'd1,
    MODE_1024x768 = 2'd2,
    MODE_1280x720 = 2'd3
  } mode_t;

  typedef struct packed {
    logic [11:0] h_res;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_res;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        h_pol;   // 1 = sync pulse is high
    logic        v_pol;
  } timing_t;

  localparam timing_t MODE_TABLE [0:3] = '{
    '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0},
    '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1},
    '{12'd1024, 12'd24,  12'd136, 12'd160, 12'd768, 12'd3,  12'd6, 12'd29, 1'b0, 1'b0},
    '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 1'b1}
  };

  // Counter constants; blanking sits at negative coordinates so that the
  // visible area starts at (0,0).
  typedef struct packed {
    int   h_sta;
    int   hs_sta;
    int   hs_end;
    int   ha_end;
    int   v_sta;
    int   vs_sta;
    int   vs_end;
    int   va_end;
    logic h_pol;
    logic v_pol;
  } derived_t;

  function automatic derived_t derive(mode_t m);
    timing_t  t;
    derived_t d;
    int       hb;
    int       vb;
    t        = MODE_TABLE[m];
    hb       = int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    vb       = int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    d.h_sta  = -hb;
    d.hs_sta = -hb + int'(t.h_fp);
    d.hs_end = -hb + int'(t.h_fp) + int'(t.h_sync);
    d.ha_end = int'(t.h_res) - 1;
    d.v_sta  = -vb;
    d.vs_sta = -vb + int'(t.v_fp);
    d.vs_end = -vb + int'(t.v_fp) + int'(t.v_sync);
    d.va_end = int'(t.v_res) - 1;
    d.h_pol  = t.h_pol;
    d.v_pol  = t.v_pol;
    return d;
  endfunction

endpackage

// File: rtl/display_timing_multi_if.sv
// display_timing_multi_if
// Mode-change handshake between a controller (master) and the timing
// generator (slave).
//   mode_req  : one-cycle request, mode_sel sampled with it
//   mode_sel  : requested mode
//   mode_ack  : one-cycle pulse when the new mode is in effect
//   mode_busy : a request is pending
//   mode_cur  : mode currently driving timing
interface display_timing_multi_if;
  logic       mode_req;
  logic [1:0] mode_sel;
  logic       mode_ack;
  logic       mode_busy;
  logic [1:0] mode_cur;

  modport master (output mode_req, mode_sel, input mode_ack, mode_busy, mode_cur);
  modport slave  (input mode_req, mode_sel, output mode_ack, mode_busy, mode_cur);
endinterface

// File: rtl/display_timing_multi_rom.sv
// display_mode_rom
// Combinational lookup: mode -> signed counter constants and sync polarities.
//   mode                          : selected mode
//   h_sta/hs_sta/hs_end/ha_end    : horizontal start, sync start/end, last active
//   v_sta/vs_sta/vs_end/va_end    : vertical equivalents
//   h_pol/v_pol                   : sync active level
module display_mode_rom
  import display_timing_pkg::*;
#(
  parameter int CORDW = 12
) (
  input  mode_t                   mode,
  output logic signed [CORDW-1:0] h_sta,
  output logic signed [CORDW-1:0] hs_sta,
  output logic signed [CORDW-1:0] hs_end,
  output logic signed [CORDW-1:0] ha_end,
  output logic signed [CORDW-1:0] v_sta,
  output logic signed [CORDW-1:0] vs_sta,
  output logic signed [CORDW-1:0] vs_end,
  output logic signed [CORDW-1:0] va_end,
  output logic                    h_pol,
  output logic                    v_pol
);
  derived_t d;

  assign d      = derive(mode);
  assign h_sta  = CORDW'(d.h_sta);
  assign hs_sta = CORDW'(d.hs_sta);
  assign hs_end = CORDW'(d.hs_end);
  assign ha_end = CORDW'(d.ha_end);
  assign v_sta  = CORDW'(d.v_sta);
  assign vs_sta = CORDW'(d.vs_sta);
  assign vs_end = CORDW'(d.vs_end);
  assign va_end = CORDW'(d.va_end);
  assign h_pol  = d.h_pol;
  assign v_pol  = d.v_pol;
endmodule

// File: rtl/display_timing_multi.sv
// display_timing_multi
// Runtime-selectable video timing generator with a four-entry mode table.
// Mode changes are requested over the handshake interface and applied only at
// a frame boundary, so every frame is produced entirely in one mode.
//   clk_pix, rst_pix_n : pixel clock, asynchronous active-low reset
//   mif (slave)        : mode_req/mode_sel in, mode_ack/mode_busy/mode_cur out
//   hsync, vsync       : syncs with per-mode polarity
//   de, frame, line    : data enable, start-of-frame and start-of-line strobes
//   sx, sy             : signed screen coordinates (blanking is negative)
//   frame_cnt          : frame counter, only when DISPLAY_FRAME_CNT_EN is
//                        defined; otherwise tied to zero
module display_timing_multi
  import display_timing_pkg::*;
#(
  parameter int         CORDW    = 12,
  parameter logic [1:0] MODE_RST = 2'd2,
  parameter int         FCW      = 16
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  display_timing_multi_if.slave   mif,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic                    frame,
  output logic                    line,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic [FCW-1:0]          frame_cnt
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  localparam derived_t RST_D = derive(mode_t'(MODE_RST));
  localparam logic signed [CORDW-1:0] RST_HSTA = CORDW'(RST_D.h_sta);
  localparam logic signed [CORDW-1:0] RST_VSTA = CORDW'(RST_D.v_sta);

  logic [0:0]              state;
  mode_t                   mode_cur_q;
  mode_t                   pend_mode;
  logic signed [CORDW-1:0] x_p0;
  logic signed [CORDW-1:0] y_p0;
  logic                    sw_p0;

  logic signed [CORDW-1:0] c_h_sta, c_hs_sta, c_hs_end, c_ha_end;
  logic signed [CORDW-1:0] c_v_sta, c_vs_sta, c_vs_end, c_va_end;
  logic                    c_h_pol, c_v_pol;
  logic signed [CORDW-1:0] n_h_sta, n_hs_sta, n_hs_end, n_ha_end;
  logic signed [CORDW-1:0] n_v_sta, n_vs_sta, n_vs_end, n_va_end;
  logic                    n_h_pol, n_v_pol;
  logic                    unused_pend_consts;

  logic eol;
  logic eof;
  logic do_switch;

  display_mode_rom #(.CORDW(CORDW)) u_rom_cur (
    .mode   (mode_cur_q),
    .h_sta  (c_h_sta),  .hs_sta (c_hs_sta), .hs_end (c_hs_end), .ha_end (c_ha_end),
    .v_sta  (c_v_sta),  .vs_sta (c_vs_sta), .vs_end (c_vs_end), .va_end (c_va_end),
    .h_pol  (c_h_pol),  .v_pol  (c_v_pol)
  );

  // Only the start positions of the pending mode are needed: they seed the
  // counters on the switch edge; everything else follows from mode_cur.
  display_mode_rom #(.CORDW(CORDW)) u_rom_pend (
    .mode   (pend_mode),
    .h_sta  (n_h_sta),  .hs_sta (n_hs_sta), .hs_end (n_hs_end), .ha_end (n_ha_end),
    .v_sta  (n_v_sta),  .vs_sta (n_vs_sta), .vs_end (n_vs_end), .va_end (n_va_end),
    .h_pol  (n_h_pol),  .v_pol  (n_v_pol)
  );

  assign unused_pend_consts = &{1'b0, n_hs_sta, n_hs_end, n_ha_end,
                                n_vs_sta, n_vs_end, n_va_end, n_h_pol, n_v_pol};

  assign eol       = (x_p0 == c_ha_end);
  assign eof       = eol && (y_p0 == c_va_end);
  assign do_switch = eof && (state == ST_PEND);

  assign mif.mode_busy = (state == ST_PEND);
  assign mif.mode_cur  = mode_cur_q;

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state        <= ST_IDLE;
      pend_mode    <= mode_t'(MODE_RST);
      mode_cur_q   <= mode_t'(MODE_RST);
      x_p0         <= RST_HSTA;
      y_p0         <= RST_VSTA;
      sw_p0        <= 1'b0;
      sx           <= RST_HSTA;
      sy           <= RST_VSTA;
      de           <= 1'b0;
      frame        <= 1'b0;
      line         <= 1'b0;
      hsync        <= ~RST_D.h_pol;
      vsync        <= ~RST_D.v_pol;
      mif.mode_ack <= 1'b0;
    end else begin
      // ---- stage p0: position counters and mode switch ----
      sw_p0 <= do_switch;
      if (do_switch) begin
        // pend_mode here is the value before this edge, so a request landing
        // in the boundary cycle only affects the next frame.
        mode_cur_q <= pend_mode;
        x_p0       <= n_h_sta;
        y_p0       <= n_v_sta;
      end else if (eol) begin
        x_p0 <= c_h_sta;
        y_p0 <= eof ? c_v_sta : y_p0 + 1'b1;
      end else begin
        x_p0 <= x_p0 + 1'b1;
      end

      if (mif.mode_req) begin
        pend_mode <= mode_t'(mif.mode_sel);
        state     <= ST_PEND;
      end else if (do_switch) begin
        state <= ST_IDLE;
      end

      // ---- stage p1: registered video outputs ----
      sx           <= x_p0;
      sy           <= y_p0;
      de           <= !x_p0[CORDW-1] && !y_p0[CORDW-1];
      frame        <= (x_p0 == c_h_sta) && (y_p0 == c_v_sta);
      line         <= (x_p0 == c_h_sta);
      hsync        <= (x_p0 > c_hs_sta && x_p0 <= c_hs_end) ? c_h_pol : ~c_h_pol;
      vsync        <= (y_p0 > c_vs_sta && y_p0 <= c_vs_end) ? c_v_pol : ~c_v_pol;
      mif.mode_ack <= sw_p0;
    end
  end

`ifdef DISPLAY_FRAME_CNT_EN
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      frame_cnt <= '0;
    end else if (frame) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_display_timing_multi.sv
module tb_display_timing_multi;

  typedef struct {
    int mode;
    int sx;
    int sy;
  } ack_t;

`ifdef DISPLAY_FRAME_CNT_EN
  localparam int FC_EXP = 3;
`else
  localparam int FC_EXP = 0;
`endif

  logic               clk_pix = 1'b0;
  logic               rst_pix_n = 1'b0;
  logic               hsync, vsync, de, frame, line;
  logic signed [11:0] sx, sy;
  logic [15:0]        frame_cnt;
  logic signed [11:0] jump_y;

  ack_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  display_timing_multi_if mif();

  display_timing_multi #(.CORDW(12), .MODE_RST(2'd2), .FCW(16)) dut (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .mif       (mif),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .frame     (frame),
    .line      (line),
    .sx        (sx),
    .sy        (sy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest expected switch.
  always @(negedge clk_pix) begin
    if (rst_pix_n && mif.mode_ack) begin
      chk("ack_was_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        ack_t r;
        r = exp_q.pop_front();
        chk("ack_mode_cur", int'(mif.mode_cur), r.mode);
        chk("ack_sx", int'(sx), r.sx);
        chk("ack_sy", int'(sy), r.sy);
        chk("ack_with_frame", int'(frame), 1);
      end
    end
  end

  task automatic wait_line();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_pix);
      if (line) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("line_timeout", 0, 1);
  endtask

  task automatic wait_frame(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_pix);
      if (frame) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic wait_ack(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_pix);
      if (mif.mode_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, int'(ok), 1);
  endtask

  // Move the vertical counter to a chosen line, just after a line start,
  // so long frames can be skipped.
  task automatic jump(input int v);
    wait_line();
    jump_y = 12'(v);
    force dut.y_p0 = jump_y;
    @(negedge clk_pix);
    release dut.y_p0;
  endtask

  task automatic measure_line(input logic pol, output int period, output int act,
                              output int den, output int mn, output int mx);
    period = 0; act = 0; den = 0; mn = 4096; mx = -4096;
    wait_line();
    do begin
      if (hsync == pol) act++;
      if (de) den++;
      if (int'(sx) < mn) mn = int'(sx);
      if (int'(sx) > mx) mx = int'(sx);
      period++;
      @(negedge clk_pix);
    end while (!line && period < 4000);
  endtask

  task automatic issue_req(input int sel);
    mif.mode_req = 1'b1;
    mif.mode_sel = 2'(sel);
    @(negedge clk_pix);
    mif.mode_req = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_sx"}, int'(sx), -320);
    chk({tag, "_sy"}, int'(sy), -38);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_frame"}, int'(frame), 0);
    chk({tag, "_line"}, int'(line), 0);
    chk({tag, "_hsync"}, int'(hsync), 1);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_mode_cur"}, int'(mif.mode_cur), 2);
    chk({tag, "_busy"}, int'(mif.mode_busy), 0);
    chk({tag, "_ack"}, int'(mif.mode_ack), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  initial begin
    int  per, act, den, mn, mx, vs;
    bit  found;
    mif.mode_req = 1'b0;
    mif.mode_sel = 2'd0;

    // Reset state of mode 2
    #22;
    check_reset("rst");
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);
    chk("first_frame", int'(frame), 1);
    chk("first_sx", int'(sx), -320);
    chk("first_sy", int'(sy), -38);

    // Mode 2 line timing
    measure_line(1'b0, per, act, den, mn, mx);
    chk("m2_line_period", per, 1344);
    chk("m2_hsync_low", act, 136);
    chk("m2_blank_de", den, 0);
    jump(5);
    measure_line(1'b0, per, act, den, mn, mx);
    chk("m2_active_de", den, 1024);
    jump(-36);
    vs = 0;
    for (int i = 0; i < 8; i++) begin
      wait_line();
      if (!vsync) vs++;
    end
    chk("m2_vsync_lines", vs, 6);

    // Mid-frame switch to mode 0
    exp_q.push_back('{0, -160, -45});
    issue_req(0);
    chk("m0_busy_req", int'(mif.mode_busy), 1);
    jump(767);
    chk("m0_busy_hold", int'(mif.mode_busy), 1);
    wait_ack("m0_ack_seen");
    chk("m0_busy_clear", int'(mif.mode_busy), 0);
    measure_line(1'b0, per, act, den, mn, mx);
    chk("m0_line_period", per, 800);
    chk("m0_hsync_low", act, 96);

    // Switch to mode 3
    exp_q.push_back('{3, -370, -30});
    issue_req(3);
    jump(479);
    wait_ack("m3_ack_seen");
    measure_line(1'b1, per, act, den, mn, mx);
    chk("m3_line_period", per, 1650);
    chk("m3_hsync_high", act, 40);
    chk("m3_sx_min", mn, -370);
    chk("m3_sx_max", mx, 1279);

    // Two requests in one frame, latest wins (current mode again)
    exp_q.push_back('{3, -370, -30});
    issue_req(1);
    repeat (3) @(negedge clk_pix);
    issue_req(3);
    chk("dbl_busy", int'(mif.mode_busy), 1);
    jump(719);
    wait_ack("dbl_ack_seen");
    repeat (300) @(negedge clk_pix);
    chk("dbl_mode_cur", int'(mif.mode_cur), 3);
    chk("dbl_busy_clear", int'(mif.mode_busy), 0);

    // Request landing in the boundary cycle is deferred one frame
    jump(719);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_pix);
      if (sx == 12'sd1278 && sy == 12'sd719) begin
        found = 1'b1;
        break;
      end
    end
    chk("bnd_found", int'(found), 1);
    issue_req(0);
    @(negedge clk_pix);
    chk("bnd_frame", int'(frame), 1);
    chk("bnd_mode_kept", int'(mif.mode_cur), 3);
    chk("bnd_busy", int'(mif.mode_busy), 1);
    exp_q.push_back('{0, -160, -45});
    jump(719);
    wait_ack("bnd_ack_seen");

    // Asynchronous reset with a request pending
    issue_req(1);
    chk("rst_busy_before", int'(mif.mode_busy), 1);
    @(posedge clk_pix);
    #3;
    rst_pix_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    @(negedge clk_pix);
    chk("rst_frame1", int'(frame), 1);
    jump(767);
    wait_frame("rst_frame2");
    jump(767);
    wait_frame("rst_frame3");
    repeat (2) @(negedge clk_pix);
    chk("frame_cnt_3", int'(frame_cnt), FC_EXP);
    chk("rst_mode_cur", int'(mif.mode_cur), 2);
    chk("rst_busy_after", int'(mif.mode_busy), 0);
    repeat (50) @(negedge clk_pix);

    chk("ack_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
